cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares the single word-wide main-memory port between I-cache refills and D-cache refills/writebacks.
//  Sequences each granted request as a BLOCK_BEATS-beat burst, assembles or serialises the full line, and returns one ready pulse.
//  Sits between the icache/dcache FSMs and the memory interface.
//  The I-cache FSM holds ic_rden until ic_ready; ALLOCATE_2 raises a new request on the next block.
// PARAMETERS
//  ADDR_W       32  byte-address width
//  DATA_W       32  memory beat width (bits)
//  BLOCK_BEATS  4   beats per cache line; line = BLOCK_BEATS*DATA_W = 128 b (16 B); power of 2, >=2
// PORTS
//  clk        in   1                   clock, rising edge
//  rst        in   1                   reset, asynchronous, active-high
//  ic_rden    in   1                   I-cache refill request, level, held until ic_ready
//  ic_addr    in   ADDR_W              I-cache refill address (any byte in line)
//  ic_ready   out  1                   1-cycle pulse: ic_rdata valid, request done
//  ic_rdata   out  BLOCK_BEATS*DATA_W  refilled line, beat 0 in LSBs
//  dc_rden    in   1                   D-cache refill request, level
//  dc_wren    in   1                   D-cache writeback request, level
//  dc_addr    in   ADDR_W              D-cache line address
//  dc_wdata   in   BLOCK_BEATS*DATA_W  writeback line, stable while dc_wren high
//  dc_ready   out  1                   1-cycle pulse: read data valid / write done
//  dc_rdata   out  BLOCK_BEATS*DATA_W  refilled line
//  mem_req    out  1                   beat request, held until mem_ack
//  mem_we     out  1                   1 = write beat
//  mem_addr   out  ADDR_W              beat byte address
//  mem_wdata  out  DATA_W              write beat data
//  mem_ack    in   1                   beat accepted; mem_rdata valid same cycle on reads
//  mem_rdata  in   DATA_W              read beat data
//  busy       out  1                   high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; beat_cnt, line buffer, base address and last_grant cleared.
//  - Reset mid-burst: abandon burst immediately; no ready pulse issued.
//  - States:
//    - IDLE: if any request, select winner, latch base = addr with low log2(BLOCK_BEATS*DATA_W/8) bits zeroed.
//      - Latch op: write for dc_wren; a write latches dc_wdata into the line buffer.
//      - Clear beat_cnt; go BURST.
//    - BURST: mem_req=1, mem_we=op, mem_addr = base + beat_cnt*(DATA_W/8), mem_wdata = buffer[beat_cnt].
//      - mem_ack=1: on reads, buffer[beat_cnt] <= mem_rdata; beat_cnt++.
//      - mem_ack=1 on last beat: go RESP.
//    - RESP: one-cycle ready pulse to the winner; ic_rdata/dc_rdata = buffer; update last_grant; go IDLE.
//  - Latency, zero-wait memory: request seen in IDLE -> ready at cycle 2+BLOCK_BEATS. Min 6 cycles for BLOCK_BEATS=4.
//  - mem_ack outside BURST is ignored. Requests arriving during BURST wait; no preemption.
//  - dc_wren and dc_rden together: writeback is served first, then refill (writeback-before-refill).
//  - ic_rdata/dc_rdata hold their value after the ready pulse until the next completion for that requester.
//  - Requester must drop or change its request the cycle after ready; re-sampling happens in IDLE only.
//  - beat_cnt width log2(BLOCK_BEATS); address increments wrap only within the line and never carry into the tag.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin between I-side and D-side.
//    - On simultaneous requests the side not granted last wins.
//    - last_grant resets to D-side, so the first tie goes to the I-cache.
//  MEM_ARB_RR_EN undefined: fixed priority, D-cache always wins ties; last_grant logic is absent.
// TESTING
//  1. ic_rden, addr 0x0000_1234, mem_ack every cycle, rdata 0xA0..0xA3 -> mem_addr 0x1230,0x1234,0x1238,0x123C;
//     ic_ready at cycle 6; ic_rdata = {A3,A2,A1,A0}.
//  2. dc_wren, addr 0x40, wdata {D3,D2,D1,D0}, mem_ack every 3rd cycle -> 4 write beats 0x40..0x4C, data D0..D3, mem_we=1;
//     one dc_ready pulse; ic_ready stays 0.
//  3. ic_rden and dc_rden rise the same cycle -> fixed: D first, then I; RR_EN: I first, then D.
//     Exactly one ready pulse each, no overlap.
//  4. rst asserted in beat 2 of an I refill -> same cycle: mem_req=0, busy=0, no ic_ready; new request after release restarts at beat 0.
//  5. dc_wren+dc_rden, addr 0x80 -> write burst completes before read burst begins; two dc_ready pulses.
//  6. Back-to-back I requests 0x1FFC then 0x2000 (misaligned fetch) -> two bursts at base 0x1FF0 and 0x2000, two ic_ready pulses.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one word-wide main-memory port between I-cache
// refills and D-cache refills/writebacks. Each granted request runs as one
// BLOCK_BEATS-beat burst and finishes with a single ready pulse.
// Build option: define MEM_ARB_RR_EN for round-robin I/D arbitration on ties;
// left undefined, the D-cache wins every tie.
module cache_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BLOCK_BEATS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ic_rden,
    input  logic [ADDR_W-1:0]             ic_addr,
    output logic                          ic_ready,
    output logic [BLOCK_BEATS*DATA_W-1:0] ic_rdata,
    input  logic                          dc_rden,
    input  logic                          dc_wren,
    input  logic [ADDR_W-1:0]             dc_addr,
    input  logic [BLOCK_BEATS*DATA_W-1:0] dc_wdata,
    output logic                          dc_ready,
    output logic [BLOCK_BEATS*DATA_W-1:0] dc_rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy
);

    localparam int CNT_W  = $clog2(BLOCK_BEATS);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int OFF_W  = CNT_W + BYTE_W;
    // Clears the byte-in-line offset so a burst always starts at the line base.
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                               state;
    state_t                               state_nxt;
    logic [CNT_W-1:0]                     beat_cnt;
    logic [BLOCK_BEATS-1:0][DATA_W-1:0]   line_buf;
    logic [ADDR_W-1:0]                    base;
    logic                                 op_we;
    logic                                 win_d;
    logic                                 grant_d;
    logic                                 any_req;
    logic                                 last_beat;
    logic [BLOCK_BEATS*DATA_W-1:0]        ic_line_q;
    logic [BLOCK_BEATS*DATA_W-1:0]        dc_line_q;

    assign any_req   = ic_rden | dc_rden | dc_wren;
    assign last_beat = (beat_cnt == CNT_W'(BLOCK_BEATS - 1));

`ifdef MEM_ARB_RR_EN
    logic last_grant_d;

    // Remember which side completed last; a reset leaves D as "last" so the first tie goes to I.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant_d <= 1'b1;
        else if (state == RESP)
            last_grant_d <= win_d;
    end

    // On a tie the side that was not granted last wins.
    always_comb begin
        grant_d = (dc_rden | dc_wren) & (~ic_rden | ~last_grant_d);
    end
`else
    // Fixed priority: any D-side request beats the I-side.
    always_comb begin
        grant_d = dc_rden | dc_wren;
    end
`endif

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state: IDLE -> BURST on any request, BURST -> RESP on the last acked beat, RESP -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BURST;
            BURST:   if (mem_ack && last_beat) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winner in IDLE, collect or serialise beats in BURST, publish the line in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt  <= '0;
            line_buf  <= '0;
            base      <= '0;
            op_we     <= 1'b0;
            win_d     <= 1'b0;
            ic_line_q <= '0;
            dc_line_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win_d    <= grant_d;
                        op_we    <= grant_d & dc_wren;
                        base     <= (grant_d ? dc_addr : ic_addr) & LINE_MASK;
                        beat_cnt <= '0;
                        // Writebacks take precedence over a refill on the D side.
                        if (grant_d && dc_wren)
                            line_buf <= dc_wdata;
                    end
                end
                BURST: begin
                    if (mem_ack) begin
                        if (!op_we)
                            line_buf[beat_cnt] <= mem_rdata;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (!win_d)
                        ic_line_q <= line_buf;
                    else if (!op_we)
                        dc_line_q <= line_buf;
                end
                default: ;
            endcase
        end
    end

    // Memory port, ready pulses and held line outputs, all decoded from the current state.
    always_comb begin
        mem_req   = (state == BURST);
        mem_we    = (state == BURST) & op_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == BURST) begin
            // Beat index only fills the offset bits, so the address never carries into the tag.
            mem_addr  = base | (ADDR_W'(beat_cnt) << BYTE_W);
            mem_wdata = line_buf[beat_cnt];
        end
        busy     = (state != IDLE);
        ic_ready = (state == RESP) & ~win_d;
        dc_ready = (state == RESP) & win_d;
        ic_rdata = ic_ready ? line_buf : ic_line_q;
        dc_rdata = (dc_ready && !op_we) ? line_buf : dc_line_q;
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: table of request scenarios, hand-written
// multi-cycle sequences (latency, reset mid-burst, back-to-back fetches) and
// randomized rounds, all checked against a transaction-level reference model.
module tb_cache_mem_arbiter;

    localparam int BB = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_rden, dc_rden, dc_wren;
    logic [31:0]   ic_addr, dc_addr;
    logic [127:0]  dc_wdata;
    logic          ic_ready, dc_ready;
    logic [127:0]  ic_rdata, dc_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata;
    logic          busy;

    int tests = 0;
    int fails = 0;
    bit seq_mode = 1'b0;
    int ack_ctr = 0;
    bit last_d_m = 1'b1;

    typedef struct {
        bit           is_d;
        bit           we;
        logic [31:0]  base;
        logic [127:0] wdata;
    } txn_t;
    txn_t expq[$];

    typedef struct {
        bit           ic, dr, dw;
        logic [31:0]  ia, da;
        logic [127:0] wd;
        int           amode;
        int           e_ic, e_dc, e_first_fixed, e_first_rr;
    } vec_t;
    vec_t vt[7];

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BLOCK_BEATS(BB)) dut (
        .clk(clk), .rst(rst),
        .ic_rden(ic_rden), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
        .dc_rden(dc_rden), .dc_wren(dc_wren), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ready(dc_ready), .dc_rdata(dc_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input bit s);
        if (s) return 32'hA0 + {30'b0, a[3:2]};
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
    endfunction

    always_comb mem_rdata = mem_word(mem_addr, seq_mode);

    function automatic logic [127:0] model_line(input logic [31:0] b);
        logic [127:0] l;
        for (int i = 0; i < BB; i++) l[i*32 +: 32] = mem_word(b + 32'(i * 4), seq_mode);
        return l;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event occurred, got 1 want 0", name);
    endtask

    task automatic drive_ack(input int amode);
        case (amode)
            0: mem_ack = 1'b1;
            1: mem_ack = (ack_ctr % 3 == 2);
            default: mem_ack = 1'($urandom_range(0, 1));
        endcase
        ack_ctr++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ic_rden = 0; dc_rden = 0; dc_wren = 0; mem_ack = 0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0;
        @(negedge clk);
        check("rst_ctrl", {mem_req, mem_we, busy, ic_ready, dc_ready}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_ic_rdata", ic_rdata, 0);
        check("rst_dc_rdata", dc_rdata, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        last_d_m = 1'b1;
    endtask

    // One scenario: requests raised together, each requester holds until its ready,
    // then drops. The model predicts the service order and every beat.
    task automatic run_round(input bit ic, input bit dr, input bit dw,
                             input logic [31:0] ia, input logic [31:0] da,
                             input logic [127:0] wd, input int amode,
                             output int n_ic, output int n_dc, output int first_d);
        bit pi, pr, pw, pick, got_ic;
        txn_t t;
        int bcnt, cyc;
        logic [127:0] line_exp, last_ic_line;
        expq.delete();
        pi = ic; pr = dr; pw = dw;
        while (pi || pr || pw) begin
            pick = (pr || pw) && (!pi || !RR || !last_d_m);
            t.is_d  = pick;
            t.we    = pick && pw;
            t.base  = (pick ? da : ia) & 32'hFFFF_FFF0;
            t.wdata = wd;
            if (!pick) pi = 0; else if (pw) pw = 0; else pr = 0;
            last_d_m = pick;
            expq.push_back(t);
        end
        n_ic = 0; n_dc = 0;
        first_d = (expq.size() != 0) ? int'(expq[0].is_d) : -1;
        pi = ic; pr = dr; pw = dw;
        bcnt = 0; cyc = 0; got_ic = 0; ack_ctr = 0;
        line_exp = '0; last_ic_line = '0;
        @(posedge clk); #1;
        ic_rden = pi; dc_rden = pr; dc_wren = pw;
        ic_addr = ia; dc_addr = da; dc_wdata = wd;
        drive_ack(amode);
        while (1) begin
            @(negedge clk);
            if (mem_req && mem_ack) begin
                if (expq.size() == 0 || bcnt >= BB) fail_now("extra_beat");
                else begin
                    t = expq[0];
                    check("beat_addr", mem_addr, t.base + 32'(bcnt * 4));
                    check("beat_we", mem_we, t.we);
                    if (t.we) check("beat_wdata", mem_wdata, t.wdata[bcnt*32 +: 32]);
                    bcnt++;
                end
            end
            if (ic_ready && dc_ready) fail_now("ready_overlap");
            if (ic_ready || dc_ready) begin
                if (expq.size() == 0) fail_now("extra_ready");
                else begin
                    t = expq.pop_front();
                    check("ready_side", dc_ready, t.is_d);
                    check("beat_count", bcnt, BB);
                    line_exp = model_line(t.base);
                    if (ic_ready) check("ic_rdata", ic_rdata, line_exp);
                    else if (!t.we) check("dc_rdata", dc_rdata, line_exp);
                end
                if (ic_ready) begin n_ic++; pi = 0; got_ic = 1; last_ic_line = line_exp; end
                if (dc_ready) begin
                    n_dc++;
                    if (pw && (!pr || t.we)) pw = 0; else pr = 0;
                end
                bcnt = 0;
            end
            if (!(pi || pr || pw)) break;
            cyc++;
            if (cyc > 600) begin fail_now("round_timeout"); break; end
            @(posedge clk); #1;
            ic_rden = pi; dc_rden = pr; dc_wren = pw;
            drive_ack(amode);
        end
        check("pending_txns", expq.size(), 0);
        if (got_ic) check("ic_rdata_hold", ic_rdata, last_ic_line);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n_ic, n_dc, first, n, exp_first;
        bit got, found;

        vt[0] = '{1, 0, 0, 32'h0000_1234, 32'h0, 128'h0, 0, 1, 0, 0, 0};
        vt[1] = '{0, 0, 1, 32'h0, 32'h0000_0040,
                  128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000, 1, 0, 1, 1, 1};
        vt[2] = '{1, 1, 0, 32'h0000_3000, 32'h0000_7008, 128'h0, 0, 1, 1, 1, 0};
        vt[3] = '{0, 1, 1, 32'h0, 32'h0000_0080,
                  128'h11112222_33334444_55556666_77778888, 2, 0, 2, 1, 1};
        vt[4] = '{1, 1, 1, 32'h0000_0044, 32'h0000_9990,
                  128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 2, 1, 2, 1, 0};
        vt[5] = '{1, 0, 0, 32'h0000_1FFC, 32'h0, 128'h0, 1, 1, 0, 0, 0};
        vt[6] = '{0, 1, 0, 32'h0, 32'hFFFF_FFF4, 128'h0, 2, 0, 1, 1, 1};

        do_reset();

        // Single I refill, zero-wait memory, fixed data pattern: latency and line assembly.
        seq_mode = 1'b1;
        @(posedge clk); #1;
        ic_addr = 32'h0000_1234; ic_rden = 1'b1; mem_ack = 1'b1;
        n = 0; got = 0;
        for (int c = 1; c <= 12 && !got; c++) begin
            @(negedge clk);
            if (mem_req && mem_ack) begin
                check("t1_addr", mem_addr, 32'h0000_1230 + 32'(n * 4));
                n++;
            end
            if (ic_ready) begin
                got = 1;
                check("t1_latency", c, 6);
                check("t1_rdata", ic_rdata, 128'h000000A3_000000A2_000000A1_000000A0);
            end
        end
        if (!got) fail_now("t1_no_ready");
        check("t1_beats", n, 4);
        @(posedge clk); #1;
        ic_rden = 1'b0;
        seq_mode = 1'b0;

        // Scenario table, each row from reset.
        for (int k = 0; k < 7; k++) begin
            do_reset();
            run_round(vt[k].ic, vt[k].dr, vt[k].dw, vt[k].ia, vt[k].da, vt[k].wd,
                      vt[k].amode, n_ic, n_dc, first);
            exp_first = RR ? vt[k].e_first_rr : vt[k].e_first_fixed;
            check($sformatf("v%0d_ic_pulses", k), n_ic, vt[k].e_ic);
            check($sformatf("v%0d_dc_pulses", k), n_dc, vt[k].e_dc);
            check($sformatf("v%0d_first_d", k), first, exp_first);
        end

        // Reset asserted during beat 2 of an I refill, then restart from beat 0.
        do_reset();
        @(posedge clk); #1;
        ic_addr = 32'h0000_5678; ic_rden = 1'b1; mem_ack = 1'b1;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'h0000_5678) found = 1;
        end
        if (!found) fail_now("t4_no_beat2");
        #1 rst = 1'b1;
        #1;
        check("t4_mem_req", mem_req, 0);
        check("t4_busy", busy, 0);
        check("t4_ic_ready", ic_ready, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("t4_rst_ready", {ic_ready, dc_ready, mem_req}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        last_d_m = 1'b1;
        run_round(1, 0, 0, 32'h0000_5678, 32'h0, 128'h0, 0, n_ic, n_dc, first);
        check("t4_restart_ic", n_ic, 1);

        // Back-to-back misaligned I fetches across a line boundary.
        do_reset();
        run_round(1, 0, 0, 32'h0000_1FFC, 32'h0, 128'h0, 0, n_ic, n_dc, first);
        check("t6_first_ic", n_ic, 1);
        run_round(1, 0, 0, 32'h0000_2000, 32'h0, 128'h0, 0, n_ic, n_dc, first);
        check("t6_second_ic", n_ic, 1);

        // Randomized rounds; arbitration history carries across rounds.
        for (int r = 0; r < 60; r++) begin
            bit ric, rdr, rdw;
            ric = 1'($urandom_range(0, 1));
            rdr = 1'($urandom_range(0, 1));
            rdw = 1'($urandom_range(0, 1));
            if (!(ric || rdr || rdw)) ric = 1'b1;
            run_round(ric, rdr, rdw, $urandom, $urandom,
                      {$urandom, $urandom, $urandom, $urandom},
                      int'($urandom_range(0, 2)), n_ic, n_dc, first);
            check("rand_ic_pulses", n_ic, int'(ric));
            check("rand_dc_pulses", n_dc, int'(rdr) + int'(rdw));
        end
        @(posedge clk); #1;
        ic_rden = 0; dc_rden = 0; dc_wren = 0; mem_ack = 0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
